err_meas_sched: RTL

//  Sequences the error-statistics accumulators (avg_err / avg_err_squared) for MER/DC-offset measurement.

---
 rtl/err_meas_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/err_meas_sched.sv
// Window sequencer for the avg_err / avg_err_squared accumulators: counts symbols into
// 2^LFSR_WID windows, pulses their shared clear, then captures the latched statistics.
module err_meas_sched #(
  parameter int unsigned LFSR_WID = 22,
  parameter int unsigned SETTLE   = 2
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        sym_clk_en,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  input  logic [17:0] err_acc_in,
  input  logic [17:0] err_sq_in,
  output logic        clr_acc,
  output logic        busy,
  output logic        meas_valid,
  output logic [17:0] dc_err,
  output logic [17:0] mse,
  output logic [15:0] win_cnt
);

  localparam int unsigned    SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DUMP,
    S_SETTLE,
    S_FLUSH
  } state_t;

  state_t              state, state_nxt;
  logic [LFSR_WID-1:0] sym_cnt;
  logic [SW-1:0]       settle_cnt;
  logic                sym_clr, sym_inc, capture, win_clr;

  always_ff @(posedge sys_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // abort outranks both the window end and the capture
  always_comb begin
    state_nxt = state;
    sym_clr   = 1'b0;
    sym_inc   = 1'b0;
    capture   = 1'b0;
    win_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ARM;
          win_clr   = 1'b1;
        end
      end
      S_ARM: begin
        sym_clr   = 1'b1;
        state_nxt = abort ? S_FLUSH : S_RUN;
      end
      S_RUN: begin
        sym_inc = sym_clk_en;
        if (abort)                            state_nxt = S_FLUSH;
        else if (sym_clk_en && sym_cnt == '1) state_nxt = S_DUMP;
      end
      S_DUMP: state_nxt = abort ? S_FLUSH : S_SETTLE;
      S_SETTLE: begin
        sym_inc = sym_clk_en;
        if (abort) state_nxt = S_FLUSH;
        else if (settle_cnt == SETTLE_LAST) begin
          capture   = 1'b1;
          state_nxt = continuous ? S_RUN : S_IDLE;
        end
      end
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode the next state so they leave a flop aligned with the state they describe
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      clr_acc    <= 1'b0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      dc_err     <= '0;
      mse        <= '0;
      win_cnt    <= '0;
      sym_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      clr_acc    <= (state_nxt == S_ARM) || (state_nxt == S_DUMP) || (state_nxt == S_FLUSH);
      busy       <= (state_nxt != S_IDLE);
      meas_valid <= capture;
      if (capture) begin
        dc_err <= err_acc_in;
        mse    <= err_sq_in;
      end
      if (win_clr)      win_cnt <= '0;
      else if (capture) win_cnt <= win_cnt + 16'd1;
      if (sym_clr)      sym_cnt <= '0;
      else if (sym_inc) sym_cnt <= sym_cnt + 1'b1;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
    end
  end

endmodule
